router_ni_packetizer: RTL and testbench

// - Network-interface packetizer feeding the router local input port (lin_flit/lin_valid/lin_ready).
// - Accepts one command (dest, payload length) plus a stream of payload words.
// - Emits a typed flit stream {type,data}: one head flit, then body flits, with the last flit marked tail.
// - One registered output slot; sustains 1 flit/cycle under no backpressure.

---
 rtl/router_ni_packetizer.sv | 93 +++++++++
 tb/tb_router_ni_packetizer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_ni_packetizer.sv
// router_ni_packetizer: turns a (dest, len) command plus payload words into a head/body/tail flit stream
// Ports: clock, reset (sync, active-high); cmd_valid_i/cmd_ready_o/cmd_dest_i/cmd_len_i command;
// data_valid_i/data_ready_o/data_i payload; flit_o/flit_valid_o/flit_ready_i router local input.
// Optional ROUTER_NI_STATS_EN adds pkt_count_o/flit_count_o accepted-flit statistics.
module router_ni_packetizer #(
    parameter int TYPE_W = 2,
    parameter int DATA_W = 32,
    parameter int DEST_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [DEST_W-1:0]        cmd_dest_i,
    input  logic [LEN_W-1:0]         cmd_len_i,
    input  logic                     data_valid_i,
    output logic                     data_ready_o,
    input  logic [DATA_W-1:0]        data_i,
    output logic [TYPE_W+DATA_W-1:0] flit_o,
    output logic                     flit_valid_o,
    input  logic                     flit_ready_i
`ifdef ROUTER_NI_STATS_EN
    ,
    output logic [31:0]              pkt_count_o,
    output logic [31:0]              flit_count_o
`endif
);
    localparam logic [TYPE_W-1:0] T_BODY   = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] T_HEAD   = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] T_TAIL   = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_SINGLE = TYPE_W'(3);

    typedef enum logic {IDLE, PAYLOAD} state_t;
    state_t state, state_next;

    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] head_data;
    logic              load_ok, cmd_fire, data_fire, last_word;

    // The slot can be reloaded whenever it is empty or draining this cycle.
    always_comb begin
        load_ok      = !flit_valid_o || flit_ready_i;
        cmd_ready_o  = (state == IDLE) && load_ok;
        data_ready_o = (state == PAYLOAD) && load_ok;
        cmd_fire     = cmd_valid_i && cmd_ready_o;
        data_fire    = data_valid_i && data_ready_o;
        last_word    = remaining == LEN_W'(1);
        head_data    = '0;
        head_data[DATA_W-1 -: DEST_W] = cmd_dest_i;
        head_data[LEN_W-1:0]          = cmd_len_i;
        state_next   = state;
        if (cmd_fire && cmd_len_i != '0)
            state_next = PAYLOAD;
        else if (data_fire && last_word)
            state_next = IDLE;
    end

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            flit_valid_o <= 1'b0;
            flit_o       <= '0;
            remaining    <= '0;
        end else if (cmd_fire) begin
            flit_o       <= {cmd_len_i == '0 ? T_SINGLE : T_HEAD, head_data};
            flit_valid_o <= 1'b1;
            remaining    <= cmd_len_i;
        end else if (data_fire) begin
            flit_o       <= {last_word ? T_TAIL : T_BODY, data_i};
            flit_valid_o <= 1'b1;
            remaining    <= remaining - LEN_W'(1);
        end else if (flit_ready_i) begin
            flit_valid_o <= 1'b0;
        end
    end

`ifdef ROUTER_NI_STATS_EN
    // HEAD and SINGLE both carry a 1 in the type LSB, marking a packet start.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count_o  <= '0;
            flit_count_o <= '0;
        end else if (flit_valid_o && flit_ready_i) begin
            flit_count_o <= flit_count_o + 32'd1;
            if (flit_o[DATA_W])
                pkt_count_o <= pkt_count_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_router_ni_packetizer.sv
// tb_router_ni_packetizer: directed vector table plus randomized scoreboard check of the packetizer
module tb_router_ni_packetizer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_ready_o;
    logic [7:0]  cmd_dest_i = '0, cmd_len_i = '0;
    logic        data_valid_i = 1'b0, data_ready_o;
    logic [31:0] data_i = '0;
    logic [33:0] flit_o;
    logic        flit_valid_o;
    logic        flit_ready_i = 1'b1;
`ifdef ROUTER_NI_STATS_EN
    logic [31:0] pkt_count_o, flit_count_o;
`endif

    router_ni_packetizer dut (
        .clock(clock), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_dest_i(cmd_dest_i), .cmd_len_i(cmd_len_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i)
`ifdef ROUTER_NI_STATS_EN
        , .pkt_count_o(pkt_count_o), .flit_count_o(flit_count_o)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        cv;
        logic [7:0]  dest;
        logic [7:0]  len;
        logic        dv;
        logic [31:0] data;
        logic        fr;
        logic        ecr;
        logic        edr;
        logic        efv;
        logic [33:0] eflit;
    } vec_t;

    int tests = 0, failed = 0;
    logic [33:0] exp_q[$];
    logic sb_on = 1'b1, bp = 1'b0, fired_c, fired_d, prev_hold = 1'b0;
    logic [33:0] prev_flit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        tests++;
        failed++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic vec_t v(input logic cv, input logic [7:0] dest, input logic [7:0] len,
                               input logic dv, input logic [31:0] data, input logic fr,
                               input logic ecr, input logic edr, input logic efv, input logic [33:0] eflit);
        vec_t r;
        r.cv = cv; r.dest = dest; r.len = len; r.dv = dv; r.data = data; r.fr = fr;
        r.ecr = ecr; r.edr = edr; r.efv = efv; r.eflit = eflit;
        return r;
    endfunction

    // One clock of the randomized phase: called at a negedge with inputs already driven.
    task automatic cycle();
        flit_ready_i = bp ? ($urandom % 3 != 0) : 1'b1;
        #1;
        if (prev_hold) begin
            chk("hold_valid", 64'(flit_valid_o), 64'd1);
            chk("hold_flit", 64'(flit_o), 64'(prev_flit));
        end
        if (flit_valid_o && !flit_ready_i) begin
            chk("bp_cmd_ready", 64'(cmd_ready_o), 64'd0);
            chk("bp_data_ready", 64'(data_ready_o), 64'd0);
        end
        if (sb_on && flit_valid_o && flit_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_flit", 64'(flit_o), 64'h3_ffff_ffff_dead);
            else chk("flit", 64'(flit_o), 64'(exp_q.pop_front()));
        end
        prev_hold = flit_valid_o && !flit_ready_i;
        prev_flit = flit_o;
        fired_c = cmd_valid_i && cmd_ready_o;
        fired_d = data_valid_i && data_ready_o;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_packet(input logic [7:0] dest, input logic [7:0] len);
        logic [31:0] w[$];
        int n;
        for (int i = 0; i < int'(len); i++) w.push_back($urandom);
        exp_q.push_back({(len == 0) ? 2'b11 : 2'b01, dest, 16'h0, len});
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back({(i == int'(len) - 1) ? 2'b10 : 2'b00, w[i]});
        cmd_valid_i = 1'b1; cmd_dest_i = dest; cmd_len_i = len;
        fired_c = 1'b0; n = 0;
        while (!fired_c && n < 200) begin
            cycle();
            n++;
        end
        if (!fired_c) note_fail("cmd_accept");
        cmd_valid_i = 1'b0;
        n = 0;
        for (int i = 0; i < int'(len); ) begin
            data_valid_i = ($urandom % 4) != 0;
            data_i = w[i];
            cycle();
            if (fired_d) i++;
            else if (++n > 2000) begin
                note_fail("data_accept");
                break;
            end
        end
        data_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid_i = 1'b0; data_valid_i = 1'b0;
        while (exp_q.size() > 0 && n < 2000) begin
            cycle();
            n++;
        end
        if (exp_q.size() > 0) note_fail("drain");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[22];
        logic [31:0] a = 32'hA0A0_0001, b = 32'hB0B0_0002, c = 32'hC0C0_0003;
        logic [31:0] d = 32'hD0D0_0004, e = 32'hE0E0_0005;
        vt[0]  = v(1, 8'h05, 0, 0, 0, 1,  1, 0, 0, '0);
        vt[1]  = v(0, 0, 0, 0, 0, 1,      1, 0, 1, {2'b11, 32'h0500_0000});
        vt[2]  = v(1, 8'h12, 3, 0, 0, 1,  1, 0, 0, '0);
        vt[3]  = v(0, 0, 0, 1, a, 1,      0, 1, 1, {2'b01, 32'h1200_0003});
        vt[4]  = v(1, 8'h99, 1, 1, b, 1,  0, 1, 1, {2'b00, a});
        vt[5]  = v(0, 0, 0, 1, c, 1,      0, 1, 1, {2'b00, b});
        vt[6]  = v(0, 0, 0, 0, 0, 1,      1, 0, 1, {2'b10, c});
        vt[7]  = v(1, 8'h12, 3, 0, 0, 1,  1, 0, 0, '0);
        vt[8]  = v(0, 0, 0, 1, a, 1,      0, 1, 1, {2'b01, 32'h1200_0003});
        vt[9]  = v(0, 0, 0, 1, b, 0,      0, 0, 1, {2'b00, a});
        vt[10] = v(0, 0, 0, 1, b, 0,      0, 0, 1, {2'b00, a});
        vt[11] = v(0, 0, 0, 1, b, 0,      0, 0, 1, {2'b00, a});
        vt[12] = v(0, 0, 0, 1, b, 1,      0, 1, 1, {2'b00, a});
        vt[13] = v(0, 0, 0, 1, c, 1,      0, 1, 1, {2'b00, b});
        vt[14] = v(0, 0, 0, 0, 0, 1,      1, 0, 1, {2'b10, c});
        vt[15] = v(1, 8'h33, 1, 0, 0, 1,  1, 0, 0, '0);
        vt[16] = v(0, 0, 0, 1, d, 1,      0, 1, 1, {2'b01, 32'h3300_0001});
        vt[17] = v(1, 8'h44, 1, 0, 0, 1,  1, 0, 1, {2'b10, d});
        vt[18] = v(0, 0, 0, 1, e, 1,      0, 1, 1, {2'b01, 32'h4400_0001});
        vt[19] = v(0, 0, 0, 0, 0, 1,      1, 0, 1, {2'b10, e});
        vt[20] = v(0, 0, 0, 1, 32'hF00D, 1, 1, 0, 0, '0);
        vt[21] = v(0, 0, 0, 0, 0, 1,      1, 0, 0, '0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_flit_valid", 64'(flit_valid_o), 64'd0);
        chk("rst_flit", 64'(flit_o), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_data_ready", 64'(data_ready_o), 64'd0);

        foreach (vt[i]) begin
            cmd_valid_i = vt[i].cv; cmd_dest_i = vt[i].dest; cmd_len_i = vt[i].len;
            data_valid_i = vt[i].dv; data_i = vt[i].data; flit_ready_i = vt[i].fr;
            #1;
            chk($sformatf("vec%0d_cmd_ready", i), 64'(cmd_ready_o), 64'(vt[i].ecr));
            chk($sformatf("vec%0d_data_ready", i), 64'(data_ready_o), 64'(vt[i].edr));
            chk($sformatf("vec%0d_flit_valid", i), 64'(flit_valid_o), 64'(vt[i].efv));
            if (vt[i].efv) chk($sformatf("vec%0d_flit", i), 64'(flit_o), 64'(vt[i].eflit));
            @(posedge clock);
            @(negedge clock);
        end
        cmd_valid_i = 1'b0; data_valid_i = 1'b0;

        // Reset in the middle of a 5-word packet, then a clean packet.
        sb_on = 1'b0; bp = 1'b0;
        cmd_valid_i = 1'b1; cmd_dest_i = 8'h77; cmd_len_i = 8'd5;
        cycle();
        chk("midrst_cmd_fired", 64'(fired_c), 64'd1);
        cmd_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 32'h1;
        cycle();
        data_i = 32'h2;
        cycle();
        data_valid_i = 1'b0; reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("midrst_flit_valid", 64'(flit_valid_o), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("midrst_data_ready", 64'(data_ready_o), 64'd0);
        exp_q.delete(); prev_hold = 1'b0; sb_on = 1'b1;
        send_packet(8'h09, 8'd1);
        drain();

        // Maximum length packet under random backpressure.
        bp = 1'b1;
        send_packet(8'hAB, 8'd255);
        drain();

        // Random packets with random backpressure and data gaps.
        for (int p = 0; p < 40; p++) begin
            bp = ($urandom % 2) != 0;
            send_packet(8'($urandom), ($urandom % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
        end
        drain();

`ifdef ROUTER_NI_STATS_EN
        bp = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0; prev_hold = 1'b0;
        send_packet(8'h01, 8'd0);
        send_packet(8'h02, 8'd2);
        send_packet(8'h03, 8'd4);
        drain();
        chk("pkt_count", 64'(pkt_count_o), 64'd3);
        chk("flit_count", 64'(flit_count_o), 64'd9);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
